// File: rtl/bus_interfaces_pkg.sv
// bus_interfaces_pkg
//   Shared AXI-Stream channel types plus the egress arbiter's FSM state type
//   and source-count ceiling.
//   axis_m2s_t : master-to-slave fields (tvalid, tdata[63:0], tkeep[7:0],
//                tuser[63:0], tlast)
//   axis_s2m_t : slave-to-master fields (tready)
package bus_interfaces_pkg;

    localparam int ARB_MAX_SRC = 16;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic [63:0] tuser;
        logic        tlast;
    } axis_m2s_t;

    typedef struct packed {
        logic tready;
    } axis_s2m_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/egress_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. It scans upward from last+1, wrapping
//   modulo NUM_SRC, and returns the first requester it finds.
//   req    : one request bit per source
//   last   : index of the previous winner
//   winner : selected index; 0 when found is low
//   found  : high when any bit of req is set
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    int cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        // Distance 1 is checked first, so the nearest requester after
        // 'last' wins. The previous winner comes last, at distance NUM_SRC.
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = (int'(last) + i) % NUM_SRC;
            if (!found && req[cand[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/egress_rr_arbiter.sv
// egress_rr_arbiter
//   Arbitrates NUM_SRC AXI-Stream sources onto one egress stream. Grants are
//   round-robin and hold for a whole packet. The output passes through one
//   register stage.
//   clk, rst   : rising-edge clock; asynchronous active-high reset
//   s_axis_m2s : per-source beats in
//   s_axis_s2m : per-source tready; only the granted source can see it high
//   m_axis_m2s : registered merged stream out
//   m_axis_s2m : downstream tready
//   grant_id   : current or most recent granted source
//   busy       : high while a packet holds the lock
//   pkt_cnt    : per-source count of completed packets, present only when
//                EGRESS_ARB_STATS_EN is defined; wraps at 2^32
//   NUM_SRC may be 2..ARB_MAX_SRC.
module egress_rr_arbiter
    import bus_interfaces_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  axis_m2s_t [NUM_SRC-1:0]   s_axis_m2s,
    output axis_s2m_t [NUM_SRC-1:0]   s_axis_s2m,
    output axis_m2s_t                 m_axis_m2s,
    input  axis_s2m_t                 m_axis_s2m,
    output logic [SEL_W-1:0]          grant_id,
    output logic                      busy
`ifdef EGRESS_ARB_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]  pkt_cnt
`endif
);

    arb_state_t           state;
    logic [SEL_W-1:0]     last_grant;
    logic [NUM_SRC-1:0]   req;
    logic [SEL_W-1:0]     pick;
    logic                 pick_found;
    axis_m2s_t            out_q;
    axis_m2s_t            sel_beat;
    logic                 out_ready;
    logic                 grant_ready;
    logic                 accept;

    always_comb begin
        req = '0;
        for (int g = 0; g < NUM_SRC; g++)
            req[g] = s_axis_m2s[g].tvalid;
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (req),
        .last   (last_grant),
        .winner (pick),
        .found  (pick_found)
    );

    // The output register can take a new beat when it is empty or when its
    // current beat is leaving this cycle.
    assign sel_beat    = s_axis_m2s[grant_id];
    assign out_ready   = !out_q.tvalid || m_axis_s2m.tready;
    assign grant_ready = (state == LOCKED) && out_ready;
    assign accept      = grant_ready && sel_beat.tvalid;

    always_comb begin
        for (int g = 0; g < NUM_SRC; g++)
            s_axis_s2m[g].tready = grant_ready && (grant_id == SEL_W'(g));
    end

    // Arbitration FSM. A grant is taken only in IDLE, so after every tlast
    // there is exactly one arbitration cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SEL_W'(NUM_SRC - 1);
            grant_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= LOCKED;
                        grant_id   <= pick;
                        last_grant <= pick;
                    end
                end
                LOCKED: begin
                    if (accept && sel_beat.tlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single output stage. An empty slot is driven to all-zero so that no
    // stale payload is left behind a low tvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else if (out_ready)
            out_q <= accept ? sel_beat : '0;
    end

    assign m_axis_m2s = out_q;
    assign busy       = (state == LOCKED);

`ifdef EGRESS_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            for (int g = 0; g < NUM_SRC; g++)
                if (accept && sel_beat.tlast && grant_id == SEL_W'(g))
                    pkt_cnt[g] <= pkt_cnt[g] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// tb_egress_rr_arbiter
//   Self-checking bench for egress_rr_arbiter with NUM_SRC=4. It runs a
//   table-driven two-source sequence, then directed multi-cycle scenarios,
//   then randomized traffic. Every cycle is compared against a cycle-level
//   reference model. Statistics checks run only when EGRESS_ARB_STATS_EN is
//   defined.
module tb_egress_rr_arbiter;
    import bus_interfaces_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    axis_m2s_t [N-1:0] s_m2s;
    axis_s2m_t [N-1:0] s_s2m;
    axis_m2s_t         m_m2s;
    axis_s2m_t         m_s2m;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef EGRESS_ARB_STATS_EN
    logic [N-1:0][31:0] pkt_cnt;
`endif

    egress_rr_arbiter #(.NUM_SRC(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis_m2s (s_m2s),
        .s_axis_s2m (s_s2m),
        .m_axis_m2s (m_m2s),
        .m_axis_s2m (m_s2m),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef EGRESS_ARB_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source drivers: each source has a queue of packet lengths to send.
    int  q_len[N][$];
    int  beat[N];
    int  pid[N];
    bit  present[N];
    bit  rand_vld;
    int  rdy_mode;
    int  stall_lo, stall_hi;
    int  cyc;

    // Reference model state
    bit          md_locked;
    int          md_g, md_last, md_gid;
    axis_m2s_t   md_out;
    logic [31:0] md_cnt[N];

    // Observation logs, indexed by cycle since reset release
    logic [63:0] obs[$];
    int          gnt_log[$];
    bit          tv_log[$];
    axis_m2s_t   m_log[$];
    logic [N-1:0] rdy_log[$];
    int          last_tlast[N];
    int          first_rdy[N];
    int          beats_in;
    bit          prev_busy;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  d0;
        logic [7:0]  d2;
        logic        rdy;
        logic        ebusy;
        logic [1:0]  egid;
        logic [3:0]  etrdy;
        logic        eov;
        logic        elast;
        logic [15:0] edata;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic axis_m2s_t make_beat(input int s);
        axis_m2s_t b;
        b.tvalid = 1'b1;
        b.tdata  = {8'(s), 24'(pid[s]), 32'(beat[s])};
        b.tkeep  = 8'(beat[s] * 37 + s);
        b.tuser  = ~b.tdata ^ 64'(pid[s]);
        b.tlast  = (beat[s] == q_len[s][0] - 1);
        return b;
    endfunction

    task automatic drive();
        for (int s = 0; s < N; s++)
            s_m2s[s] = present[s] ? make_beat(s) : '0;
    endtask

    task automatic reeval();
        for (int s = 0; s < N; s++)
            if (!present[s] && q_len[s].size() > 0 && (!rand_vld || $urandom_range(3) != 0))
                present[s] = 1'b1;
    endtask

    task automatic set_rdy();
        case (rdy_mode)
            0:       m_s2m.tready = 1'b1;
            1:       m_s2m.tready = ($urandom_range(3) != 0);
            default: m_s2m.tready = !(cyc >= stall_lo && cyc <= stall_hi);
        endcase
    endtask

    task automatic model_reset();
        md_locked = 1'b0;
        md_g      = 0;
        md_last   = N - 1;
        md_gid    = 0;
        md_out    = '0;
        for (int s = 0; s < N; s++) md_cnt[s] = '0;
    endtask

    task automatic clear_src();
        for (int s = 0; s < N; s++) begin
            q_len[s].delete();
            beat[s]       = 0;
            pid[s]        = 0;
            present[s]    = 1'b0;
            last_tlast[s] = -1;
            first_rdy[s]  = -1;
        end
        obs.delete(); gnt_log.delete(); tv_log.delete(); m_log.delete(); rdy_log.delete();
        beats_in  = 0;
        prev_busy = 1'b0;
    endtask

    // Reference model for one edge. Downstream takes a new beat only when its
    // single slot is free or draining. The grant holds until the granted
    // source's tlast is taken, and a new grant goes to the nearest requester
    // after the previous winner.
    task automatic model_update();
        bit slot_free, took, found;
        slot_free = !md_out.tvalid || m_s2m.tready;
        took      = md_locked && s_m2s[md_g].tvalid && slot_free;
        if (slot_free) md_out = took ? s_m2s[md_g] : '0;
        if (!md_locked) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (md_last + k) % N;
                if (!found && s_m2s[idx].tvalid) begin
                    found = 1'b1; md_locked = 1'b1;
                    md_g = idx; md_last = idx; md_gid = idx;
                end
            end
        end else if (took && s_m2s[md_g].tlast) begin
            md_locked = 1'b0;
            md_cnt[md_g] = md_cnt[md_g] + 32'd1;
        end
    endtask

    // One clock cycle, entered and left at a negedge with inputs applied.
    task automatic cycle();
        logic [N-1:0] acc;
        logic [N-1:0] rv;
        #1;
        chk("busy", 256'(busy), 256'(md_locked));
        chk("grant_id", 256'(grant_id), 256'(md_gid));
        for (int s = 0; s < N; s++)
            chk($sformatf("tready%0d", s), 256'(s_s2m[s].tready),
                256'(md_locked && s == md_g && (!md_out.tvalid || m_s2m.tready)));
        chk("m_axis", 256'(m_m2s), 256'(md_out));
`ifdef EGRESS_ARB_STATS_EN
        for (int s = 0; s < N; s++)
            chk($sformatf("pkt_cnt%0d", s), 256'(pkt_cnt[s]), 256'(md_cnt[s]));
`endif
        for (int s = 0; s < N; s++) begin
            rv[s]  = s_s2m[s].tready;
            acc[s] = s_s2m[s].tready && s_m2s[s].tvalid;
            if (acc[s]) begin
                beats_in++;
                if (s_m2s[s].tlast) last_tlast[s] = cyc;
            end
            if (s_s2m[s].tready && first_rdy[s] < 0) first_rdy[s] = cyc;
        end
        if (busy && !prev_busy) gnt_log.push_back(int'(grant_id));
        prev_busy = busy;
        tv_log.push_back(m_m2s.tvalid);
        m_log.push_back(m_m2s);
        rdy_log.push_back(rv);
        if (m_m2s.tvalid && m_s2m.tready) obs.push_back(m_m2s.tdata);
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        cyc++;
        for (int s = 0; s < N; s++)
            if (acc[s]) begin
                if (s_m2s[s].tlast) begin
                    void'(q_len[s].pop_front());
                    beat[s] = 0;
                    pid[s]++;
                end else begin
                    beat[s]++;
                end
                present[s] = 1'b0;
            end
        reeval();
        set_rdy();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        clear_src();
        drive();
        cycle();
        cycle();
        clear_src();
        rst = 1'b0;
        cyc = 0;
        set_rdy();
        drive();
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < maxc) begin
            pend = md_locked || md_out.tvalid;
            for (int s = 0; s < N; s++)
                if (q_len[s].size() > 0 || present[s]) pend = 1'b1;
            if (pend) begin
                cycle();
                n++;
            end
        end
        chk("drain_timeout", 256'(n < maxc), 256'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int total;
        int exp_p[N];
        int exp_b[N];
        int lens[N][$];

        tbl[0] = '{4'b0101, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{4'b0101, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{4'b0101, 4'b0000, 8'd1, 8'd0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 16'h0000};
        tbl[3] = '{4'b0101, 4'b0001, 8'd2, 8'd0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 16'h0001};
        tbl[4] = '{4'b0100, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 16'h0002};
        tbl[5] = '{4'b0100, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 16'h0000};
        tbl[6] = '{4'b0100, 4'b0000, 8'd0, 8'd1, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 16'h0200};
        tbl[7] = '{4'b0100, 4'b0100, 8'd0, 8'd2, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 16'h0201};
        tbl[8] = '{4'b0000, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b1, 16'h0202};
        tbl[9] = '{4'b0000, 4'b0000, 8'd0, 8'd0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, 16'h0000};

        rand_vld = 1'b0;
        rdy_mode = 0;
        stall_lo = 0;
        stall_hi = -1;
        cyc      = 0;
        s_m2s    = '0;
        m_s2m    = '0;
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_gid", 256'(grant_id), 256'(0));
        chk("rst_m_axis", 256'(m_m2s), 256'(0));
        chk("rst_tready", 256'(s_s2m), 256'(0));

        // Sources 0 and 2 each offer 3 beats at the same time
        @(negedge clk);
        do_reset();
        for (int r = 0; r < 10; r++) begin
            logic [3:0] tr;
            for (int s = 0; s < N; s++) begin
                s_m2s[s] = '0;
                if (tbl[r].vld[s]) begin
                    s_m2s[s].tvalid = 1'b1;
                    s_m2s[s].tlast  = tbl[r].lst[s];
                    s_m2s[s].tkeep  = 8'hFF;
                    s_m2s[s].tdata  = {48'd0, 8'(s), (s == 0) ? tbl[r].d0 : tbl[r].d2};
                end
            end
            m_s2m.tready = tbl[r].rdy;
            #1;
            for (int s = 0; s < N; s++) tr[s] = s_s2m[s].tready;
            chk($sformatf("tbl%0d_busy", r), 256'(busy), 256'(tbl[r].ebusy));
            chk($sformatf("tbl%0d_gid", r), 256'(grant_id), 256'(tbl[r].egid));
            chk($sformatf("tbl%0d_tready", r), 256'(tr), 256'(tbl[r].etrdy));
            chk($sformatf("tbl%0d_tvalid", r), 256'(m_m2s.tvalid), 256'(tbl[r].eov));
            if (tbl[r].eov) begin
                chk($sformatf("tbl%0d_tdata", r), 256'(m_m2s.tdata), 256'({48'd0, tbl[r].edata}));
                chk($sformatf("tbl%0d_tlast", r), 256'(m_m2s.tlast), 256'(tbl[r].elast));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // All four sources keep offering single-beat packets
        do_reset();
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 8; k++) q_len[s].push_back(1);
        reeval(); drive();
        for (int c = 0; c < 40; c++) cycle();
        chk("rr_gnt_count", 256'(gnt_log.size() >= 8), 256'(1));
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            chk($sformatf("rr_gnt%0d", i), 256'(gnt_log[i]), 256'(i % 4));
        for (int c = 2; c < 34; c++)
            chk($sformatf("rr_tvalid_c%0d", c), 256'(tv_log[c]), 256'(c % 2 == 0));
        run_until_idle(200);

        // Downstream stall during a 4-beat packet from source 1
        do_reset();
        rdy_mode = 2; stall_lo = 2; stall_hi = 5;
        set_rdy();
        q_len[1].push_back(4);
        reeval(); drive();
        run_until_idle(100);
        chk("stall_valid", 256'(m_log[2].tvalid), 256'(1));
        for (int c = 2; c <= 5; c++) begin
            chk($sformatf("stall_hold_c%0d", c), 256'(m_log[c]), 256'(m_log[2]));
            chk($sformatf("stall_tready1_c%0d", c), 256'(rdy_log[c][1]), 256'(0));
        end
        chk("stall_beats", 256'(obs.size()), 256'(4));
        for (int i = 0; i < 4 && i < obs.size(); i++)
            chk($sformatf("stall_beat%0d", i), 256'(obs[i]), 256'({8'd1, 24'd0, 32'(i)}));
        rdy_mode = 0; stall_hi = -1;

        // Source 0 requests while source 3 holds the lock
        do_reset();
        q_len[3].push_back(4);
        reeval(); drive();
        cycle(); cycle(); cycle();
        q_len[0].push_back(2);
        reeval(); drive();
        run_until_idle(100);
        chk("lock_tlast3", 256'(last_tlast[3]), 256'(4));
        chk("lock_first_rdy0", 256'(first_rdy[0]), 256'(last_tlast[3] + 2));

        // Reset pulsed while beat 2 of a 5-beat packet is offered
        do_reset();
        q_len[2].push_back(5);
        reeval(); drive();
        cycle(); cycle(); cycle();
        chk("pre_rst_beat", 256'(beat[2]), 256'(2));
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_m_axis", 256'(m_m2s), 256'(0));
        chk("midrst_tready", 256'(s_s2m), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        @(negedge clk);
        do_reset();
        q_len[0].push_back(2);
        q_len[2].push_back(2);
        reeval(); drive();
        run_until_idle(100);
        chk("post_rst_first0", 256'(first_rdy[0]), 256'(1));
        chk("post_rst_first2", 256'(first_rdy[2]), 256'(4));

`ifdef EGRESS_ARB_STATS_EN
        // Completed-packet counters
        do_reset();
        q_len[1].push_back(2); q_len[1].push_back(1); q_len[1].push_back(3);
        q_len[2].push_back(2);
        reeval(); drive();
        run_until_idle(200);
        chk("stats0", 256'(pkt_cnt[0]), 256'(0));
        chk("stats1", 256'(pkt_cnt[1]), 256'(3));
        chk("stats2", 256'(pkt_cnt[2]), 256'(1));
        chk("stats3", 256'(pkt_cnt[3]), 256'(0));
`endif

        // Randomized traffic with random valid gaps and downstream back-pressure
        do_reset();
        rand_vld = 1'b1;
        rdy_mode = 1;
        total = 0;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 6; k++) begin
                int l;
                l = int'($urandom_range(6, 1));
                q_len[s].push_back(l);
                lens[s].push_back(l);
                total += l;
            end
            exp_p[s] = 0;
            exp_b[s] = 0;
        end
        reeval(); drive();
        run_until_idle(3000);
        chk("rand_beats_in", 256'(beats_in), 256'(total));
        chk("rand_beats_out", 256'(obs.size()), 256'(total));
        foreach (obs[i]) begin
            int s;
            s = int'(obs[i][63:56]);
            if (s < N && lens[s].size() > 0) begin
                chk("rand_order", 256'(obs[i][55:0]), 256'({24'(exp_p[s]), 32'(exp_b[s])}));
                exp_b[s]++;
                if (exp_b[s] == lens[s][0]) begin
                    void'(lens[s].pop_front());
                    exp_b[s] = 0;
                    exp_p[s]++;
                end
            end else begin
                chk("rand_src", 256'(obs[i][63:56]), 256'(N));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
